// File: rtl/inst_queue_if.sv
// Fetch-to-decode bundle for the instruction queue.
// The master side is fetch plus decode; the slave side is the queue itself.
interface inst_queue_if #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned INST_W  = 32,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned FETCH_N = 2,
  parameter int unsigned ISSUE_N = 2
);
  logic                             fetchValid;
  logic [FETCH_N*INST_W-1:0]        fetchData;
  logic [ADDR_W-1:0]                fetchPc;
  logic                             fetchReady;
  logic [ISSUE_N-1:0]               outValid;
  logic [ISSUE_N*INST_W-1:0]        outInst;
  logic [ISSUE_N*ADDR_W-1:0]        outPc;
  logic [$clog2(ISSUE_N+1)-1:0]     deqCount;
  logic                             flush;
  logic [$clog2(DEPTH+1)-1:0]       count;
  logic                             empty;
  logic                             full;

  modport master (
    output fetchValid, fetchData, fetchPc, deqCount, flush,
    input  fetchReady, outValid, outInst, outPc, count, empty, full
  );

  modport slave (
    input  fetchValid, fetchData, fetchPc, deqCount, flush,
    output fetchReady, outValid, outInst, outPc, count, empty, full
  );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction fetch queue: FETCH_N-wide enqueue with PC tagging,
// ISSUE_N-wide in-order presentation, variable dequeue and one-cycle flush.
module inst_queue #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned INST_W  = 32,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned FETCH_N = 2,
  parameter int unsigned ISSUE_N = 2
) (
  input  logic         clk,
  input  logic         reset,
  inst_queue_if.slave  bus
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned PC_STEP = INST_W / 8;

  logic [INST_W-1:0] instMem [DEPTH];
  logic [ADDR_W-1:0] pcMem   [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  deqReq;
  logic [CNT_W-1:0]  deq;
  logic              ready;
  logic              enq;

  // Space check looks at registered occupancy only, never at this cycle's dequeue.
  assign ready  = (count <= CNT_W'(DEPTH - FETCH_N));
  assign enq    = bus.fetchValid & ready & ~bus.flush;
  assign deqReq = CNT_W'(bus.deqCount);
  assign deq    = (deqReq < count) ? deqReq : count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(FETCH_N);
      head  <= head + PTR_W'(deq);
      count <= count + (enq ? CNT_W'(FETCH_N) : '0) - deq;
    end
  end

  // Storage carries no reset; validity is defined purely by head and count.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int unsigned i = 0; i < FETCH_N; i++) begin
        instMem[tail + PTR_W'(i)] <= bus.fetchData[(FETCH_N-1-i)*INST_W +: INST_W];
        pcMem[tail + PTR_W'(i)]   <= bus.fetchPc + ADDR_W'(i * PC_STEP);
      end
    end
  end

  always_comb begin
    bus.outValid = '0;
    bus.outInst  = '0;
    bus.outPc    = '0;
    for (int unsigned i = 0; i < ISSUE_N; i++) begin
      if (CNT_W'(i) < count) begin
        bus.outValid[i]                                 = 1'b1;
        bus.outInst[(ISSUE_N-1-i)*INST_W +: INST_W]     = instMem[head + PTR_W'(i)];
        bus.outPc[(ISSUE_N-1-i)*ADDR_W +: ADDR_W]       = pcMem[head + PTR_W'(i)];
      end
    end
  end

  assign bus.fetchReady = ready;
  assign bus.count      = count;
  assign bus.empty      = (count == '0);
  assign bus.full       = (count == CNT_W'(DEPTH));
endmodule
